// File: rtl/inst_queue_pkg.sv
// Shared frontend constants and entry layout for the dual-issue instruction queue.
package inst_queue_pkg;

  localparam int unsigned IQ_DEPTH   = 8;
  localparam int unsigned IQ_PTR_W   = 3;
  localparam int unsigned IQ_ENTRY_W = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_entry_t;

  // Decoder may signal 3; it consumes at most two entries.
  function automatic logic [1:0] iq_issue_sat(input logic [1:0] issue);
    return (issue == 2'd3) ? 2'd2 : issue;
  endfunction

endpackage

// File: rtl/inst_queue_ram.sv
// DEPTH-entry register file: two write ports, two asynchronous read ports.
module inst_queue_ram
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH,
  parameter int unsigned PTR_W = IQ_PTR_W
) (
  input  logic                  clk,
  input  logic                  we1_i,
  input  logic [PTR_W-1:0]      waddr1_i,
  input  logic [IQ_ENTRY_W-1:0] wdata1_i,
  input  logic                  we2_i,
  input  logic [PTR_W-1:0]      waddr2_i,
  input  logic [IQ_ENTRY_W-1:0] wdata2_i,
  input  logic [PTR_W-1:0]      raddr1_i,
  input  logic [PTR_W-1:0]      raddr2_i,
  output logic [IQ_ENTRY_W-1:0] rdata1_o,
  output logic [IQ_ENTRY_W-1:0] rdata2_o
);

  logic [IQ_ENTRY_W-1:0] mem_q [DEPTH];

  // The parent always drives waddr2_i = waddr1_i + 1, so the ports never collide.
  always_ff @(posedge clk) begin
    if (we1_i) mem_q[waddr1_i] <= wdata1_i;
    if (we2_i) mem_q[waddr2_i] <= wdata2_i;
  end

  assign rdata1_o = mem_q[raddr1_i];
  assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/inst_queue.sv
// Dual-issue instruction queue between the instruction cache and the decoder.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH,
  parameter int unsigned PTR_W = IQ_PTR_W,
  parameter int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid_1,
  input  logic             in_valid_2,
  input  logic [31:0]      in_inst_1,
  input  logic [31:0]      in_inst_2,
  input  logic [31:0]      in_pc,
  output logic             in_ready,
  output logic             out_valid_1,
  output logic             out_valid_2,
  output logic [31:0]      out_inst_1,
  output logic [31:0]      out_inst_2,
  output logic [31:0]      out_pc_1,
  output logic [31:0]      out_pc_2,
  input  logic [1:0]       issue_cnt,
  output logic [CNT_W-1:0] occupancy
);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [1:0]       push_n;
  logic [1:0]       pop_n;
  logic [1:0]       issue_eff;
  logic [CNT_W-1:0] free_slots;

  logic                  we1, we2;
  iq_entry_t             wentry1, wentry2;
  logic [IQ_ENTRY_W-1:0] rdata1, rdata2;
  iq_entry_t             rentry1, rentry2;

  assign free_slots = CNT_W'(DEPTH) - count_q;
  assign in_ready   = free_slots >= CNT_W'(2);

  always_comb begin
    push_n = 2'd0;
    if (in_ready && in_valid_1) begin
      push_n = in_valid_2 ? 2'd2 : 2'd1;
    end
  end

  // Over-issue is clamped to what is actually held; only count 0 or 1 can clamp.
  always_comb begin
    issue_eff = iq_issue_sat(issue_cnt);
    pop_n     = issue_eff;
    if (CNT_W'(issue_eff) > count_q) begin
      pop_n = count_q[1:0];
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop_n);
      tail_d  = tail_q + PTR_W'(push_n);
      count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign we1          = !reset && !flush && (push_n != 2'd0);
  assign we2          = !reset && !flush && (push_n == 2'd2);
  assign wentry1.pc   = in_pc;
  assign wentry1.inst = in_inst_1;
  assign wentry2.pc   = in_pc + 32'd4;
  assign wentry2.inst = in_inst_2;

  inst_queue_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk      (clk),
    .we1_i    (we1),
    .waddr1_i (tail_q),
    .wdata1_i (wentry1),
    .we2_i    (we2),
    .waddr2_i (tail_q + PTR_W'(1)),
    .wdata2_i (wentry2),
    .raddr1_i (head_q),
    .raddr2_i (head_q + PTR_W'(1)),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2)
  );

  assign rentry1 = iq_entry_t'(rdata1);
  assign rentry2 = iq_entry_t'(rdata2);

  assign out_valid_1 = count_q >= CNT_W'(1);
  assign out_valid_2 = count_q >= CNT_W'(2);
  assign out_inst_1  = out_valid_1 ? rentry1.inst : '0;
  assign out_pc_1    = out_valid_1 ? rentry1.pc   : '0;
  assign out_inst_2  = out_valid_2 ? rentry2.inst : '0;
  assign out_pc_2    = out_valid_2 ? rentry2.pc   : '0;
  assign occupancy   = count_q;

endmodule
